// File: rtl/fifo_late_drain.sv
// fifo_late_drain: 3-entry skid drain for a late-read FIFO; FIFO_DRAIN_LAST_EN adds the out_last frame counter
module fifo_late_drain #(
   parameter int DATAWIDTH = 18,
   parameter int FRAMELEN  = 256
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 fifo_ne,
   input  logic [DATAWIDTH-1:0] fifo_rd_data,
   output logic                 fifo_re,
   output logic [DATAWIDTH-1:0] out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_last,
   output logic                 err
);
   logic [1:0] occ, head, tail;
   logic re_d, cap, pop;
   logic [2:0] pend;
   logic [DATAWIDTH-1:0] mem [3];
   assign pend = {1'b0, occ} + {2'b0, re_d};
   assign fifo_re = fifo_ne && !flush && !reset && (pend <= 3'd2);
   assign cap = re_d;
   assign out_valid = occ != 2'd0;
   assign out_data = mem[head];
   assign pop = out_valid && out_ready;
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         occ <= 2'd0;
         head <= 2'd0;
         tail <= 2'd0;
         re_d <= 1'b0;
      end else begin
         re_d <= fifo_re;
         occ <= (cap && !pop) ? occ + 2'd1 : (pop && !cap) ? occ - 2'd1 : occ;
         if (cap) tail <= (tail == 2'd2) ? 2'd0 : tail + 2'd1;
         if (pop) head <= (head == 2'd2) ? 2'd0 : head + 2'd1;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) mem <= '{default: '0};
      else if (cap && !flush) mem[tail] <= fifo_rd_data;
   end
   always_ff @(posedge clk) begin
      if (reset) err <= 1'b0;
      else if (fifo_re && !fifo_ne) err <= 1'b1;
   end
`ifdef FIFO_DRAIN_LAST_EN
   logic [15:0] fcnt;
   assign out_last = out_valid && (fcnt == 16'(FRAMELEN - 1));
   always_ff @(posedge clk) begin
      if (reset || flush) fcnt <= 16'd0;
      else if (pop) fcnt <= out_last ? 16'd0 : fcnt + 16'd1;
   end
`else
   assign out_last = 1'b0 && (FRAMELEN > 0);
`endif
endmodule

// File: tb/tb_fifo_late_drain.sv
// tb_fifo_late_drain: directed self-checking bench for fifo_late_drain with a late-read FIFO model
module tb_fifo_late_drain;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic flush = 1'b0;
   logic fifo_ne;
   logic [17:0] fifo_rd_data = '0;
   logic fifo_re;
   logic [17:0] out_data;
   logic out_valid;
   logic out_ready = 1'b0;
   logic out_last;
   logic err;
   logic [17:0] fmem [0:511];
   int wp = 0;
   int rp = 0;
   int re_cnt = 0;
   int ng = 0;
   logic [17:0] got [0:511];
   logic gl [0:511];
   int n_cmp = 0;
   int n_bad = 0;

   fifo_late_drain #(.DATAWIDTH(18), .FRAMELEN(4)) dut (
      .clk(clk), .reset(reset), .flush(flush), .fifo_ne(fifo_ne),
      .fifo_rd_data(fifo_rd_data), .fifo_re(fifo_re), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .err(err)
   );

   always #5 clk = ~clk;
   assign fifo_ne = (wp != rp);

   always @(posedge clk) begin
      if (fifo_re) begin
         fifo_rd_data <= fmem[rp];
         rp <= rp + 1;
         re_cnt <= re_cnt + 1;
      end
      if (!reset && !flush && out_valid === 1'b1 && out_ready) begin
         got[ng] <= out_data;
         gl[ng] <= out_last;
         ng <= ng + 1;
      end
   end

   task automatic push(input logic [17:0] v);
      fmem[wp] = v;
      wp = wp + 1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      n_cmp++; if (out_data !== 18'h0) begin n_bad++; $display("FAIL reset_data got=%h exp=0", out_data); end
      n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL reset_last got=%b exp=0", out_last); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", err); end
      n_cmp++; if (fifo_re !== 1'b0) begin n_bad++; $display("FAIL reset_re got=%b exp=0", fifo_re); end
      reset = 1'b0;
   endtask

   task automatic test_single;
      int re0;
      @(negedge clk);
      out_ready = 1'b1;
      re0 = re_cnt;
      push(18'h155);
      #1;
      n_cmp++; if (fifo_re !== 1'b1) begin n_bad++; $display("FAIL single_re_on got=%b exp=1", fifo_re); end
      @(negedge clk);
      n_cmp++; if (fifo_re !== 1'b0) begin n_bad++; $display("FAIL single_re_off got=%b exp=0", fifo_re); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_early_valid got=%b exp=0", out_valid); end
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid got=%b exp=1", out_valid); end
      n_cmp++; if (out_data !== 18'h155) begin n_bad++; $display("FAIL single_data got=%h exp=155", out_data); end
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_drained got=%b exp=0", out_valid); end
      n_cmp++; if (re_cnt - re0 !== 1) begin n_bad++; $display("FAIL single_re_count got=%0d exp=1", re_cnt - re0); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL single_err got=%b exp=0", err); end
   endtask

   task automatic test_stream;
      int ng0, first, last, nv, bad;
      @(negedge clk);
      out_ready = 1'b1;
      ng0 = ng;
      first = -1; last = -1; nv = 0; bad = 0;
      for (int k = 0; k < 100; k++) push(18'h1000 + 18'(k));
      for (int i = 0; i < 130; i++) begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            if (first < 0) first = i;
            last = i;
            nv++;
         end
      end
      for (int k = 0; k < 100; k++) if (got[ng0 + k] !== 18'h1000 + 18'(k)) bad++;
      n_cmp++; if (nv !== 100) begin n_bad++; $display("FAIL stream_count got=%0d exp=100", nv); end
      n_cmp++; if (last - first + 1 !== 100) begin n_bad++; $display("FAIL stream_gapless got=%0d exp=100", last - first + 1); end
      n_cmp++; if (first !== 1) begin n_bad++; $display("FAIL stream_latency got=%0d exp=1", first); end
      n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL stream_order got=%0d bad exp=0", bad); end
   endtask

   task automatic test_backpressure;
      int ng0, re0, bad, held;
      logic seen;
      @(negedge clk);
      out_ready = 1'b0;
      ng0 = ng; re0 = re_cnt; bad = 0; held = 0; seen = 1'b0;
      for (int k = 0; k < 10; k++) push(18'h200 + 18'(k));
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         seen = (out_valid === 1'b1);
      end
      n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL bp_first_word got=%b exp=1", seen); end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b1 || out_data !== 18'h200) held++;
      end
      n_cmp++; if (held !== 0) begin n_bad++; $display("FAIL bp_hold got=%0d unstable exp=0", held); end
      n_cmp++; if (re_cnt - re0 !== 3) begin n_bad++; $display("FAIL bp_reads got=%0d exp=3", re_cnt - re0); end
      out_ready = 1'b1;
      repeat (10) @(negedge clk);
      n_cmp++; if (ng - ng0 !== 10) begin n_bad++; $display("FAIL bp_drain got=%0d exp=10", ng - ng0); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
      for (int k = 0; k < 10; k++) if (got[ng0 + k] !== 18'h200 + 18'(k)) bad++;
      n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL bp_order got=%0d bad exp=0", bad); end
   endtask

   task automatic test_frame;
      int ng0;
      logic done, exp_last;
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      ng0 = ng; done = 1'b0;
      for (int k = 0; k < 12; k++) push(18'h400 + 18'(k));
      for (int i = 0; i < 300 && !done; i++) begin
         out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         done = (ng - ng0 >= 12);
      end
      out_ready = 1'b1;
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL frame_timeout got=%0d exp=12", ng - ng0); end
      for (int k = 0; k < 12; k++) begin
`ifdef FIFO_DRAIN_LAST_EN
         exp_last = (k % 4 == 3);
`else
         exp_last = 1'b0;
`endif
         n_cmp++; if (got[ng0 + k] !== 18'h400 + 18'(k)) begin n_bad++; $display("FAIL frame_data[%0d] got=%h exp=%h", k, got[ng0 + k], 18'h400 + 18'(k)); end
         n_cmp++; if (gl[ng0 + k] !== exp_last) begin n_bad++; $display("FAIL frame_last[%0d] got=%b exp=%b", k, gl[ng0 + k], exp_last); end
      end
   endtask

   task automatic test_flush;
      int ng0, rp0;
      logic done, exp_last;
      @(negedge clk);
      out_ready = 1'b1;
      push(18'h300);
      repeat (4) @(negedge clk);
      out_ready = 1'b0;
      ng0 = ng; rp0 = rp; done = 1'b0;
      for (int k = 0; k < 7; k++) push(18'h310 + 18'(k));
      repeat (3) @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 18'h310) begin n_bad++; $display("FAIL flush_pre got=%b/%h exp=1/310", out_valid, out_data); end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
      n_cmp++; if (rp - rp0 !== 3) begin n_bad++; $display("FAIL flush_reads got=%0d exp=3", rp - rp0); end
      out_ready = 1'b1;
      for (int i = 0; i < 30 && !done; i++) begin
         @(negedge clk);
         done = (ng - ng0 >= 4);
      end
      repeat (5) @(negedge clk);
      n_cmp++; if (ng - ng0 !== 4) begin n_bad++; $display("FAIL flush_count got=%0d exp=4", ng - ng0); end
      for (int k = 0; k < 4; k++) begin
`ifdef FIFO_DRAIN_LAST_EN
         exp_last = (k == 3);
`else
         exp_last = 1'b0;
`endif
         n_cmp++; if (got[ng0 + k] !== 18'h313 + 18'(k)) begin n_bad++; $display("FAIL flush_data[%0d] got=%h exp=%h", k, got[ng0 + k], 18'h313 + 18'(k)); end
         n_cmp++; if (gl[ng0 + k] !== exp_last) begin n_bad++; $display("FAIL flush_last[%0d] got=%b exp=%b", k, gl[ng0 + k], exp_last); end
      end
   endtask

   task automatic test_reset_mid;
      int ng0, rp0;
      logic done, exp_last;
      @(negedge clk);
      out_ready = 1'b1;
      ng0 = ng; rp0 = rp; done = 1'b0;
      for (int k = 0; k < 9; k++) push(18'h500 + 18'(k));
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         done = (ng - ng0 >= 3);
      end
      n_cmp++; if (ng - ng0 !== 3) begin n_bad++; $display("FAIL rmid_pre got=%0d exp=3", ng - ng0); end
      reset = 1'b1;
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid got=%b exp=0", out_valid); end
      n_cmp++; if (out_data !== 18'h0) begin n_bad++; $display("FAIL rmid_data got=%h exp=0", out_data); end
      n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL rmid_last got=%b exp=0", out_last); end
      n_cmp++; if (fifo_re !== 1'b0) begin n_bad++; $display("FAIL rmid_re got=%b exp=0", fifo_re); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rmid_err got=%b exp=0", err); end
      reset = 1'b0;
      done = 1'b0;
      for (int i = 0; i < 30 && !done; i++) begin
         @(negedge clk);
         done = (ng - ng0 >= 7);
      end
      repeat (3) @(negedge clk);
      n_cmp++; if (ng - ng0 !== 7) begin n_bad++; $display("FAIL rmid_count got=%0d exp=7", ng - ng0); end
      n_cmp++; if (rp - rp0 !== 9) begin n_bad++; $display("FAIL rmid_reads got=%0d exp=9", rp - rp0); end
      for (int k = 0; k < 4; k++) begin
`ifdef FIFO_DRAIN_LAST_EN
         exp_last = (k == 3);
`else
         exp_last = 1'b0;
`endif
         n_cmp++; if (got[ng0 + 3 + k] !== 18'h505 + 18'(k)) begin n_bad++; $display("FAIL rmid_data[%0d] got=%h exp=%h", k, got[ng0 + 3 + k], 18'h505 + 18'(k)); end
         n_cmp++; if (gl[ng0 + 3 + k] !== exp_last) begin n_bad++; $display("FAIL rmid_last[%0d] got=%b exp=%b", k, gl[ng0 + 3 + k], exp_last); end
      end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL final_err got=%b exp=0", err); end
   endtask

   initial begin
      test_reset;
      test_single;
      test_stream;
      test_backpressure;
      test_frame;
      test_flush;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
